// File: rtl/alu_rs_pkg.sv
// Shared types and defaults for the ALU reservation station.
package alu_rs_pkg;

    localparam int unsigned WORD_W             = 32;
    localparam int unsigned CALC_W             = 4;
    localparam int unsigned RS_SIZE_DEFAULT    = 8;
    localparam int unsigned IQ_ADDR_W_DEFAULT  = 4;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [CALC_W-1:0] calc_code_t;

endpackage

// File: rtl/alu_rs_select.sv
// Combinational lowest-index picker over a request vector.
module alu_rs_select #(
    parameter int unsigned N     = 8,
    parameter int unsigned IDX_W = 3
) (
    input  logic [N-1:0]     ready,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        found = |ready;
        idx   = '0;
        // Walk downwards so the lowest set bit wins.
        for (int unsigned i = N; i > 0; i--) begin
            if (ready[i-1]) idx = IDX_W'(i - 1);
        end
    end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: accept phase dispatches and snoops the CDB,
// issue phase sends the lowest-index ready entry to the ALU.
module alu_rs
    import alu_rs_pkg::*;
#(
    parameter int unsigned RS_SIZE   = RS_SIZE_DEFAULT,
    parameter int unsigned IQ_ADDR_W = IQ_ADDR_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 update_stat,
    input  logic                 clear_flag_in,
    input  logic                 dispatch_enable_in,
    input  logic [CALC_W-1:0]    dispatch_calc_code_in,
    input  logic                 dispatch_lhs_ready_in,
    input  logic                 dispatch_rhs_ready_in,
    input  logic [WORD_W-1:0]    dispatch_lhs_in,
    input  logic [WORD_W-1:0]    dispatch_rhs_in,
    input  logic [IQ_ADDR_W-1:0] dispatch_pos_in_iq_in,
    output logic                 full_out,
    input  logic                 cdb_enable_in,
    input  logic [IQ_ADDR_W-1:0] cdb_tag_in,
    input  logic [WORD_W-1:0]    cdb_value_in,
    input  logic                 alu_full_in,
    output logic                 alu_calc_enable_out,
    output logic [CALC_W-1:0]    alu_calc_code_out,
    output logic [WORD_W-1:0]    alu_lhs_out,
    output logic [WORD_W-1:0]    alu_rhs_out,
    output logic [IQ_ADDR_W-1:0] alu_pos_in_iq_out
);

    localparam int unsigned IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    logic                 chip_enable;
    logic [RS_SIZE-1:0]   busy;
    logic [RS_SIZE-1:0]   lhs_rdy;
    logic [RS_SIZE-1:0]   rhs_rdy;
    word_t                lhs_val [RS_SIZE];
    word_t                rhs_val [RS_SIZE];
    calc_code_t           code    [RS_SIZE];
    logic [IQ_ADDR_W-1:0] pos     [RS_SIZE];

    logic [RS_SIZE-1:0]   issue_req;
    logic                 issue_found;
    logic [IDX_W-1:0]     issue_idx;
    logic [IDX_W-1:0]     free_idx;
    logic                 disp_lhs_rdy;
    logic                 disp_rhs_rdy;
    word_t                disp_lhs_val;
    word_t                disp_rhs_val;

    assign full_out  = &busy;
    assign issue_req = busy & lhs_rdy & rhs_rdy;

    alu_rs_select #(
        .N     (RS_SIZE),
        .IDX_W (IDX_W)
    ) u_select (
        .ready (issue_req),
        .found (issue_found),
        .idx   (issue_idx)
    );

    always_comb begin
        free_idx = '0;
        for (int unsigned i = RS_SIZE; i > 0; i--) begin
            if (!busy[i-1]) free_idx = IDX_W'(i - 1);
        end
    end

    // A not-ready operand whose producer is broadcasting this cycle is stored as ready.
    always_comb begin
        disp_lhs_rdy = dispatch_lhs_ready_in;
        disp_lhs_val = dispatch_lhs_in;
        disp_rhs_rdy = dispatch_rhs_ready_in;
        disp_rhs_val = dispatch_rhs_in;
        if (!dispatch_lhs_ready_in && cdb_enable_in &&
            dispatch_lhs_in[IQ_ADDR_W-1:0] == cdb_tag_in) begin
            disp_lhs_rdy = TRUE;
            disp_lhs_val = cdb_value_in;
        end
        if (!dispatch_rhs_ready_in && cdb_enable_in &&
            dispatch_rhs_in[IQ_ADDR_W-1:0] == cdb_tag_in) begin
            disp_rhs_rdy = TRUE;
            disp_rhs_val = cdb_value_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chip_enable         <= FALSE;
            busy                <= '0;
            lhs_rdy             <= '0;
            rhs_rdy             <= '0;
            alu_calc_enable_out <= FALSE;
            alu_calc_code_out   <= '0;
            alu_lhs_out         <= '0;
            alu_rhs_out         <= '0;
            alu_pos_in_iq_out   <= '0;
            for (int unsigned i = 0; i < RS_SIZE; i++) begin
                lhs_val[i] <= '0;
                rhs_val[i] <= '0;
                code[i]    <= '0;
                pos[i]     <= '0;
            end
        end else begin
            chip_enable <= rdy;
            if (chip_enable) begin
                if (clear_flag_in) begin
                    busy                <= '0;
                    alu_calc_enable_out <= FALSE;
                end else if (update_stat) begin
                    alu_calc_enable_out <= FALSE;
                    for (int unsigned i = 0; i < RS_SIZE; i++) begin
                        if (busy[i] && cdb_enable_in) begin
                            if (!lhs_rdy[i] && lhs_val[i][IQ_ADDR_W-1:0] == cdb_tag_in) begin
                                lhs_rdy[i] <= TRUE;
                                lhs_val[i] <= cdb_value_in;
                            end
                            if (!rhs_rdy[i] && rhs_val[i][IQ_ADDR_W-1:0] == cdb_tag_in) begin
                                rhs_rdy[i] <= TRUE;
                                rhs_val[i] <= cdb_value_in;
                            end
                        end
                    end
                    // The free slot is never busy, so this cannot collide with the snoop above.
                    if (dispatch_enable_in && !full_out) begin
                        busy[free_idx]    <= TRUE;
                        code[free_idx]    <= dispatch_calc_code_in;
                        pos[free_idx]     <= dispatch_pos_in_iq_in;
                        lhs_rdy[free_idx] <= disp_lhs_rdy;
                        lhs_val[free_idx] <= disp_lhs_val;
                        rhs_rdy[free_idx] <= disp_rhs_rdy;
                        rhs_val[free_idx] <= disp_rhs_val;
                    end
                end else begin
                    if (issue_found && !alu_full_in) begin
                        alu_calc_enable_out <= TRUE;
                        alu_calc_code_out   <= code[issue_idx];
                        alu_lhs_out         <= lhs_val[issue_idx];
                        alu_rhs_out         <= rhs_val[issue_idx];
                        alu_pos_in_iq_out   <= pos[issue_idx];
                        busy[issue_idx]     <= FALSE;
                    end else begin
                        alu_calc_enable_out <= FALSE;
                    end
                end
            end
        end
    end

endmodule

// File: doc/alu_rs.md
ALU_RS -- requirements
Module: alu_rs

Interface
REQ-001 Parameter RS_SIZE, default 8: number of reservation entries.
REQ-002 Parameter IQ_ADDR_W, default 4: width of an instruction-queue index (IqAddrType).
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 rdy  in  1  global ready; registered into internal chip_enable each cycle.
REQ-006 update_stat  in  1  phase flag. 1 = accept phase (dispatch, CDB snoop). 0 = issue phase.
REQ-007 clear_flag_in  in  1  pipeline flush.
REQ-008 dispatch_enable_in  in  1  a new ALU op is presented.
REQ-009 dispatch_calc_code_in  in  4  ALU op code 0..15 (ALU encoding).
REQ-010 dispatch_lhs_ready_in / dispatch_rhs_ready_in  in  1 each  operand value is valid.
REQ-011 dispatch_lhs_in / dispatch_rhs_in  in  32 each  operand value, or producer tag in bits [IQ_ADDR_W-1:0] when not ready.
REQ-012 dispatch_pos_in_iq_in  in  IQ_ADDR_W  destination IQ index of the op.
REQ-013 full_out  in→out  1  combinational; high when all RS_SIZE entries are busy.
REQ-014 cdb_enable_in  in  1  a result broadcast is valid.
REQ-015 cdb_tag_in  in  IQ_ADDR_W  IQ index of the broadcast producer.
REQ-016 cdb_value_in  in  32  broadcast result.
REQ-017 alu_full_in  in  1  ALU holds an undelivered result.
REQ-018 alu_calc_enable_out  out  1  registered; op valid for the ALU.
REQ-019 alu_calc_code_out  out  4  registered.
REQ-020 alu_lhs_out / alu_rhs_out  out  32 each  registered.
REQ-021 alu_pos_in_iq_out  out  IQ_ADDR_W  registered.

Function
REQ-022 When chip_enable is 0, no state or output changes, except for reset.
REQ-023 Accept phase (update_stat=1): a dispatch with full_out=0 writes the lowest-index free entry.
REQ-024 A dispatch with full_out=1 is dropped, and the bench flags it as an error.
REQ-025 Accept phase: every busy entry waiting on tag T captures cdb_value_in and marks that operand ready when cdb_enable_in=1 and cdb_tag_in=T.
REQ-026 Same-cycle dispatch and CDB: a dispatched not-ready operand whose tag equals cdb_tag_in is stored as ready with cdb_value_in.
REQ-027 Issue phase (update_stat=0): select the lowest-index busy entry with both operands ready.
REQ-028 Issue phase, when such an entry exists and alu_full_in=0: load the alu_* outputs, set alu_calc_enable_out=1, and free the entry at the same edge.
REQ-029 Otherwise, in the issue phase, set alu_calc_enable_out=0.
REQ-030 At the edge ending every accept phase, set alu_calc_enable_out=0, so an op is presented for exactly one accept cycle. Latency from both-operands-ready to ALU sampling is one issue plus one accept cycle.
REQ-031 No entry is issued twice, and an entry freed by issue is dispatchable in the next accept phase.
REQ-032 clear_flag_in=1 at an edge, in either phase, invalidates all entries, sets alu_calc_enable_out=0, and overrides dispatch, CDB and issue in that cycle.
REQ-033 Operands are stored and forwarded unmodified; the block performs no arithmetic.

Reset
REQ-034 rst=1 asynchronously clears all entry-busy bits, chip_enable and every registered output (alu_* = 0). full_out then reads 0.
REQ-035 Reset asserted mid-operation discards all held entries; no partial issue survives.

Structure
REQ-036 WordType, IqAddrType, CalcCodeType, True/False and the RS_SIZE default live in the shared defines.v.
REQ-037 A sub-module alu_rs_select (combinational lowest-index ready picker, with found flag and index output) is instantiated once.
REQ-038 Target size is 150-300 lines of RTL.

Verification
REQ-039 Dispatch ADD (code 0), lhs=5, rhs=7 (both ready), pos=3, then run an issue phase: in the following accept cycle calc_enable=1, code=0, lhs=5, rhs=7, pos=3, and it is 0 one cycle later.
REQ-040 Dispatch with lhs waiting on tag 2, then CDB tag=2 value=0x10 in a later accept phase: no issue before the CDB; the next issue presents lhs=0x10.
REQ-041 Dispatch with rhs tag 6 in the same accept cycle as CDB tag=6 value=9: the entry issues in the next issue phase with rhs=9.
REQ-042 Fill all 8 entries (not ready): full_out=1, and a 9th dispatch is dropped. Broadcast the common tag: entries 0..7 issue one per available slot, in index order.
REQ-043 Hold alu_full_in=1 with ready entries: no issue. Release it: the lowest-index entry issues.
REQ-044 Assert clear_flag_in with 4 busy entries and calc_enable=1: next cycle full_out=0, calc_enable=0, and no later issue occurs. Repeat with rst asserted mid-phase: same result, asynchronously.
